key_debouncer: RTL and testbench
================================

Name: key_debouncer

Overview:
Front-end conditioning stage for the raw `key[7:0]` bus coming from the board wrapper (TM1638 or on-board buttons). It synchronises every key into the `clock` domain and debounces each key independently with a per-key stability counter. It outputs a clean level per key, plus one-cycle press and release pulses. Downstream lab logic (LED mapping, counters, menus) consumes these outputs in place of raw `key`.

Parameters:
- N_KEYS, 8: number of independent key channels.
- STABLE_CYCLES, 270000: consecutive cycles a synchronised input must differ from the current debounced level before that level is accepted. 270000 gives 10 ms at 27 MHz. Legal range is 2 or more.
- CNT_W, 19: width of each per-key counter. Must satisfy 2^CNT_W > STABLE_CYCLES-1; violation is an elaboration error.

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- key_raw  input  N_KEYS  raw, asynchronous, bouncing key levels; 1 = pressed
- key_level  output  N_KEYS  debounced level per key
- key_press  output  N_KEYS  one-cycle pulse on each debounced 0→1 transition
- key_release  output  N_KEYS  one-cycle pulse on each debounced 1→0 transition
- key_toggle  output  N_KEYS  per-key toggle state (see Optional Feature)

Behaviour:
- One clock; reset is asynchronous and active-high.
- **Reset values:** all synchroniser flops, `key_level`, `key_press`, `key_release` and `key_toggle` are 0. All counters are 0.
- **Synchroniser:**
  - Two flops per key: `meta` then `sync`.
  - `key_raw` stable before edge E reaches `sync` at edge E+1.
- **Per-key state:** one register `level` (which drives `key_level`) and one counter `cnt`.
- **Counter rules at each edge, per key:**
  - `sync == level`: `cnt` ← 0. Any bounce back to the current level restarts the count.
  - `sync != level` and `cnt < STABLE_CYCLES-1`: `cnt` ← `cnt`+1.
  - `sync != level` and `cnt == STABLE_CYCLES-1`: `level` ← `sync`, `cnt` ← 0.
- **Latency:** raw change held from before edge E produces the `key_level` change at edge E+1+STABLE_CYCLES.
- **Pulses:**
  - `key_press[i]` and `key_release[i]` are registered.
  - Each is high for exactly the one cycle following the edge on which `level[i]` changed.
  - They are never both high for the same key.
  - Pulses for different keys are independent and may coincide.
- **Bounce shorter than STABLE_CYCLES:** no level change and no pulse.
- **Mid-count reversal:** if the input returns to `level` on the cycle the counter would have reached the threshold, no update occurs.
- **Channel independence:** channels share no state. Any number of keys may change on the same edge.
- **Reset mid-count:** the count is discarded and `level` returns to 0.
- **Key held through reset deassert:** produces a press pulse after the full latency measured from the first edge after deassert.
- **Counter range:** the counter never wraps; it is bounded by STABLE_CYCLES-1.

Optional Feature:
- **Macro:** KEY_DEBOUNCER_TOGGLE_EN.
- **Defined:** `key_toggle[i]` flips on the same edge at which `key_press[i]` asserts, i.e. it changes state once per debounced press. Release has no effect.
- **Undefined:** the `key_toggle` port still exists but is driven constant 0, and no toggle flops are built.

Test Plan (all with STABLE_CYCLES=4, CNT_W=3):
- **Clean press:** `key_raw[0]` 0→1 before edge 10 and held → `key_level[0]`=1 after edge 15. `key_press[0]` is high only in the cycle after edge 15. `key_release`=0 throughout. Other keys stay 0.
- **Bounce rejection:** `key_raw[1]` toggles 1,0,1,0 with 3-cycle high runs, then settles high → no pulse during bouncing. A single `key_press[1]` occurs 5 edges after the final stable rise is sampled.
- **Release:** key 2 is debounced high, then `key_raw[2]`→0 before edge 40 → `key_level[2]`=0 after edge 45. `key_release[2]` pulses once. `key_press[2]` stays 0.
- **Simultaneous keys:** `key_raw`=8'hFF applied before one edge → all eight `key_press` bits pulse together in one cycle, and `key_level`=8'hFF.
- **Reset mid-count:** assert `reset` two edges into a key-3 count and hold `key_raw[3]`=1 → outputs go 0 immediately (asynchronously). After deassert, `key_press[3]` arrives 5 edges after the first post-reset edge.
- **Toggle (macro defined):** three debounced presses of key 4 → `key_toggle[4]` sequence 1,0,1. With the macro undefined, `key_toggle`=0 throughout.

Source files
------------

// File: rtl/key_debouncer.sv
// ---------------------------------------------------------------------------
// key_debouncer
//
// Purpose:
//   Front-end conditioning for the raw key bus coming from the board wrapper.
//   Each key is handled independently:
//   - it is brought into the clock domain through a two-flop synchroniser;
//   - it is debounced with a per-key stability counter;
//   - it produces a clean level plus one-cycle press and release pulses.
//
// Ports:
//   clock        system clock
//   reset        asynchronous, active-high reset
//   key_raw      raw asynchronous key levels, 1 = pressed
//   key_level    debounced level per key
//   key_press    one-cycle pulse after each debounced 0->1 transition
//   key_release  one-cycle pulse after each debounced 1->0 transition
//   key_toggle   per-key toggle state, flipped once per debounced press
//
// Optional feature:
//   KEY_DEBOUNCER_TOGGLE_EN
//   - When defined, key_toggle flips on the edge that raises key_press.
//   - When undefined, key_toggle is tied to 0 and no toggle flops exist.
//
// Parameters:
//   N_KEYS         number of independent key channels
//   STABLE_CYCLES  consecutive cycles the synchronised input must differ from
//                  the debounced level before the new level is accepted (>= 2)
//   CNT_W          counter width; 2**CNT_W must exceed STABLE_CYCLES-1
// ---------------------------------------------------------------------------
module key_debouncer #(
  parameter int N_KEYS        = 8,
  parameter int STABLE_CYCLES = 270000,
  parameter int CNT_W         = 19
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N_KEYS-1:0] key_raw,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_toggle
);

  if (STABLE_CYCLES < 2) begin : g_bad_stable
    $error("key_debouncer: STABLE_CYCLES must be 2 or more");
  end

  if ((longint'(1) << CNT_W) <= (longint'(STABLE_CYCLES) - 1)) begin : g_bad_cnt_w
    $error("key_debouncer: CNT_W too narrow for STABLE_CYCLES-1");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [N_KEYS-1:0] meta_p0;
  logic [N_KEYS-1:0] sync_p1;
  logic [N_KEYS-1:0] level;
  logic [CNT_W-1:0]  cnt [N_KEYS];
  logic [N_KEYS-1:0] settle;

  // ---- stage p0/p1: two-flop synchroniser ---------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      meta_p0 <= key_raw;
      sync_p1 <= meta_p0;
    end
  end

  // A key settles on the edge where it has already disagreed with its level
  // for STABLE_CYCLES-1 edges and still disagrees now.
  always_comb begin
    settle = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      settle[i] = (sync_p1[i] != level[i]) && (cnt[i] == CNT_MAX);
    end
  end

  // ---- stage p2: stability counters, debounced level and edge pulses ------
  // The counter restarts whenever the input matches the level. It also
  // restarts on acceptance, so it never exceeds CNT_MAX and never wraps.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_KEYS; i++) begin
        cnt[i] <= '0;
      end
      level       <= '0;
      key_press   <= '0;
      key_release <= '0;
    end else begin
      for (int i = 0; i < N_KEYS; i++) begin
        if ((sync_p1[i] == level[i]) || settle[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_ONE;
        end
      end
      level       <= level ^ settle;
      key_press   <= settle & sync_p1;
      key_release <= settle & ~sync_p1;
    end
  end

  assign key_level = level;

`ifdef KEY_DEBOUNCER_TOGGLE_EN
  logic [N_KEYS-1:0] toggle_p2;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      toggle_p2 <= '0;
    end else begin
      toggle_p2 <= toggle_p2 ^ (settle & sync_p1);
    end
  end

  assign key_toggle = toggle_p2;
`else
  assign key_toggle = '0;
`endif

endmodule

// File: tb/tb_key_debouncer.sv
// ---------------------------------------------------------------------------
// tb_key_debouncer
//
// Drives directed and random key activity into key_debouncer with
// STABLE_CYCLES=4 and CNT_W=3. Each output is compared every cycle against
// a reference model:
//   - the model keeps the raw samples seen at recent clock edges;
//   - a key's level flips when the last STABLE_CYCLES synchronised samples
//     (raw delayed by two edges) all disagree with the current level.
// ---------------------------------------------------------------------------
module tb_key_debouncer;

  localparam int N  = 8;
  localparam int SC = 4;
  localparam int CW = 3;

  logic         clock;
  logic         reset;
  logic [N-1:0] key_raw;
  logic [N-1:0] key_level;
  logic [N-1:0] key_press;
  logic [N-1:0] key_release;
  logic [N-1:0] key_toggle;

  key_debouncer #(
    .N_KEYS        (N),
    .STABLE_CYCLES (SC),
    .CNT_W         (CW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .key_raw     (key_raw),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release),
    .key_toggle  (key_toggle)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state.
  // hist[0] holds the raw value sampled at the latest edge.
  // hist[k] holds the raw value sampled k edges earlier.
  logic [N-1:0] hist [0:SC+1];
  logic [N-1:0] m_level;
  logic [N-1:0] m_press;
  logic [N-1:0] m_release;
  logic [N-1:0] m_toggle;

  task automatic chk_vec(input string tag, input logic [N-1:0] got,
                         input logic [N-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k <= SC + 1; k++) hist[k] = '0;
    m_level   = '0;
    m_press   = '0;
    m_release = '0;
    m_toggle  = '0;
  endtask

  task automatic model_step(input logic [N-1:0] raw);
    logic all_diff;
    for (int k = SC + 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0]   = raw;
    m_press   = '0;
    m_release = '0;
    for (int i = 0; i < N; i++) begin
      // The synchronised samples visible to the debouncer are hist[2..SC+1].
      all_diff = 1'b1;
      for (int k = 2; k <= SC + 1; k++) begin
        if (hist[k][i] == m_level[i]) all_diff = 1'b0;
      end
      if (all_diff) begin
        m_level[i] = ~m_level[i];
        if (m_level[i]) begin
          m_press[i] = 1'b1;
`ifdef KEY_DEBOUNCER_TOGGLE_EN
          m_toggle[i] = ~m_toggle[i];
`endif
        end else begin
          m_release[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic check_all(input string phase);
    chk_vec({phase, ".level"},   key_level,   m_level);
    chk_vec({phase, ".press"},   key_press,   m_press);
    chk_vec({phase, ".release"}, key_release, m_release);
    chk_vec({phase, ".toggle"},  key_toggle,  m_toggle);
  endtask

  // One clock cycle:
  // - apply raw at the falling edge;
  // - advance the model on the rising edge;
  // - check outputs at the next falling edge.
  task automatic cycle(input logic [N-1:0] raw, input string phase);
    key_raw = raw;
    @(posedge clock);
    if (!reset) model_step(raw);
    @(negedge clock);
    check_all(phase);
  endtask

  task automatic hold(input logic [N-1:0] raw, input int n, input string phase);
    for (int c = 0; c < n; c++) cycle(raw, phase);
  endtask

  logic [N-1:0] raw_v;
  logic [N-1:0] flip;
  int           pct;

  initial begin
    reset   = 1'b1;
    key_raw = '0;
    model_clear();
    repeat (2) @(negedge clock);
    check_all("reset");
    reset = 1'b0;

    // Clean press on key 0.
    hold(8'h00, 3, "idle");
    hold(8'h01, SC + 4, "clean_press");

    // Bounce on key 1 with short high runs, then settle high.
    for (int b = 0; b < 2; b++) begin
      hold(8'h03, 3, "bounce_hi");
      hold(8'h01, 3, "bounce_lo");
    end
    hold(8'h03, SC + 4, "bounce_settle");

    // Release on key 2 after it has been debounced high.
    hold(8'h07, SC + 4, "rel_setup");
    hold(8'h03, SC + 4, "release");

    // All keys low, then all keys rise together.
    hold(8'h00, SC + 4, "all_low");
    hold(8'hFF, SC + 4, "all_high");
    hold(8'h00, SC + 4, "all_low2");

    // Reset in the middle of a key-3 count, asserted between edges.
    hold(8'h08, 3, "pre_reset");
    #2;
    reset = 1'b1;
    model_clear();
    #1;
    check_all("async_reset");
    hold(8'h08, 2, "in_reset");
    reset = 1'b0;
    hold(8'h08, SC + 4, "post_reset");

    // Three debounced presses of key 4 exercise the toggle.
    hold(8'h00, SC + 3, "tog_idle");
    for (int p = 0; p < 3; p++) begin
      hold(8'h10, SC + 3, "tog_press");
      hold(8'h00, SC + 3, "tog_release");
    end

    // Random segments with varying bounce density.
    raw_v = '0;
    for (int s = 0; s < 60; s++) begin
      case ($urandom_range(3))
        0:       pct = 0;
        1:       pct = 5;
        2:       pct = 30;
        default: pct = 60;
      endcase
      for (int c = 0; c < 20; c++) begin
        flip = '0;
        for (int i = 0; i < N; i++) begin
          flip[i] = ($urandom_range(99) < pct);
        end
        raw_v = raw_v ^ flip;
        cycle(raw_v, "random");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
